// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared constants and types for the systolic-array result path.
//   CONV_PER_BEAT : number of result words (conv1/conv2/conv3) carried by one beat
//   LAST_K        : word index of the final word written for a beat
//   writer_state_t: result_bank_writer FSM state encoding
//   word_idx_t    : type of the per-beat word counter k
package systolic_pkg;

  localparam int CONV_PER_BEAT = 3;

  typedef logic [1:0] word_idx_t;

  localparam word_idx_t LAST_K = word_idx_t'(CONV_PER_BEAT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } writer_state_t;

endpackage

// File: rtl/lane_relu.sv
// lane_relu
// Optional ReLU clamp for one signed result word on its way to a bank.
// Build option: define RESULT_WRITER_RELU_EN to clamp negative words to zero;
// without it the word passes through unchanged.
// Ports:
//   din  : signed result word from the holding buffer
//   dout : word as written to the bank
module lane_relu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Clamp on the sign bit only; zero and positive words are untouched.
  always_comb begin
`ifdef RESULT_WRITER_RELU_EN
    dout = din[DATA_WIDTH-1] ? '0 : din;
`else
    dout = din;
`endif
  end

endmodule

// File: rtl/result_bank_writer.sv
// result_bank_writer
// Accepts beats of three LANES-wide result vectors (conv1, conv2, conv3) and
// writes them as three consecutive words into LANES parallel output banks.
// Beat n of a frame occupies addresses n*3 .. n*3+2; after FRAME_BEATS beats
// the beat index wraps to zero and frame_done pulses once.
// Build option: RESULT_WRITER_RELU_EN clamps negative lane words to zero.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   enable               : global run enable, low freezes everything
//   conv_valid/ready     : beat handshake
//   conv1/conv2/conv3    : beat payload, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bram_ena/wea/addra   : shared bank port controls
//   bram_dina            : write data, lane i feeds bank i
//   frame_done           : one-cycle pulse after the last word of a frame
//   busy                 : high while a beat is being written
// FRAME_BEATS*3 must fit in the 2**ADDR_WIDTH address space.
module result_bank_writer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 8,
  parameter int ADDR_WIDTH  = 14,
  parameter int FRAME_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        conv_valid,
  output logic                        conv_ready,
  input  logic [LANES*DATA_WIDTH-1:0] conv1,
  input  logic [LANES*DATA_WIDTH-1:0] conv2,
  input  logic [LANES*DATA_WIDTH-1:0] conv3,
  output logic                        bram_ena,
  output logic                        bram_wea,
  output logic [ADDR_WIDTH-1:0]       bram_addra,
  output logic [LANES*DATA_WIDTH-1:0] bram_dina,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int VEC_W = LANES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(FRAME_BEATS - 1);

  writer_state_t         state_q, state_d;
  word_idx_t             k_q, k_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic [VEC_W-1:0]      buf1_q, buf2_q, buf3_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic                  frame_done_q;

  logic                  accept;
  logic                  write_now;
  logic                  last_word;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [VEC_W-1:0]      word_sel;

  // Handshake and write-cycle qualifiers. A write happens in every enabled
  // WRITE cycle; ready opens in IDLE and on the final word of a beat so the
  // next beat can follow with no bubble.
  always_comb begin
    write_now  = enable && (state_q == WRITE);
    last_word  = write_now && (k_q == LAST_K);
    last_beat  = (beat_q == LAST_BEAT);
    conv_ready = enable && ((state_q == IDLE) || ((state_q == WRITE) && (k_q == LAST_K)));
    accept     = conv_valid && conv_ready;
    addr_cur   = (beat_q * ADDR_WIDTH'(CONV_PER_BEAT)) + ADDR_WIDTH'(k_q);
  end

  // State register. Everything, including the holding buffer, is frozen
  // while enable is low so an interrupted beat resumes at the same word.
  // frame_done is registered so it appears the cycle after the last write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      beat_q       <= '0;
      buf1_q       <= '0;
      buf2_q       <= '0;
      buf3_q       <= '0;
      addr_hold_q  <= '0;
      frame_done_q <= 1'b0;
    end else if (enable) begin
      state_q      <= state_d;
      k_q          <= k_d;
      beat_q       <= beat_d;
      frame_done_q <= last_word && last_beat;
      if (accept) begin
        buf1_q <= conv1;
        buf2_q <= conv2;
        buf3_q <= conv3;
      end
      if (write_now) begin
        addr_hold_q <= addr_cur;
      end
    end else begin
      frame_done_q <= 1'b0;
    end
  end

  // Next-state logic. The beat index advances (and wraps at the frame end)
  // on the last word of each beat; a beat accepted on that same cycle
  // restarts the word counter without leaving WRITE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WRITE;
          k_d     = '0;
        end
      end
      WRITE: begin
        if (k_q != LAST_K) begin
          k_d = k_q + word_idx_t'(1);
        end else begin
          k_d     = '0;
          beat_d  = last_beat ? '0 : (beat_q + ADDR_WIDTH'(1));
          state_d = accept ? WRITE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Output logic. Outside write cycles the address holds the last written
  // location and the port stays disabled.
  always_comb begin
    bram_wea   = write_now;
    bram_ena   = write_now;
    bram_addra = write_now ? addr_cur : addr_hold_q;
    busy       = (state_q == WRITE);
    frame_done = frame_done_q && enable;
    case (k_q)
      2'd0:    word_sel = buf1_q;
      2'd1:    word_sel = buf2_q;
      default: word_sel = buf3_q;
    endcase
  end

  // One clamp per lane between the selected buffer word and its bank.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_relu #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_relu (
      .din (word_sel[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout(bram_dina[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_result_bank_writer.sv
// tb_result_bank_writer
// Directed bench for result_bank_writer with default parameters. Expected
// bank writes and frame_done pulses are queued as beats are issued and
// compared as the DUT produces them.
module tb_result_bank_writer;

  localparam int DW = 16;
  localparam int LN = 8;
  localparam int AW = 14;
  localparam int FB = 16;
  localparam int VW = LN * DW;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          conv_valid;
  logic          conv_ready;
  logic [VW-1:0] conv1, conv2, conv3;
  logic          bram_ena, bram_wea;
  logic [AW-1:0] bram_addra;
  logic [VW-1:0] bram_dina;
  logic          frame_done;
  logic          busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  mbeat = 0;
  int  fdSeen = 0;
  wr_t wrq[$];
  int  fdq[$];

  result_bank_writer #(
    .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .FRAME_BEATS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .conv_valid(conv_valid), .conv_ready(conv_ready),
    .conv1(conv1), .conv2(conv2), .conv3(conv3),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] w);
    logic [VW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = w;
    return v;
  endfunction

  function automatic logic [VW-1:0] pattern(input logic [DW-1:0] base);
    logic [VW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = base ^ (DW'(i) << 8);
    return v;
  endfunction

  function automatic logic [VW-1:0] reluModel(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef RESULT_WRITER_RELU_EN
    for (int i = 0; i < LN; i++)
      if (v[i*DW + DW - 1]) r[i*DW +: DW] = '0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act,
                             input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one beat and queue its expected writes. nwrites < 3 means the beat
  // is cut short by reset; stall is the number of frozen cycles inserted
  // before the k=1 word.
  task automatic applyStimulus(input logic [VW-1:0] c1, input logic [VW-1:0] c2,
                               input logic [VW-1:0] c3, input int nwrites,
                               input int stall);
    logic [VW-1:0] words [3];
    int waited;
    int acc;
    wr_t e;
    words[0] = c1;
    words[1] = c2;
    words[2] = c3;
    conv1 = c1;
    conv2 = c2;
    conv3 = c3;
    conv_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!conv_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!conv_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: conv_ready got 0 expected 1 within 64 cycles");
    end else begin
      acc = cyc;
      for (int k = 0; k < nwrites; k++) begin
        e.cyc  = acc + 1 + k + ((k > 0) ? stall : 0);
        e.addr = AW'(mbeat * 3 + k);
        e.data = reluModel(words[k]);
        wrq.push_back(e);
      end
      if (nwrites == 3) begin
        if (mbeat == FB - 1) fdq.push_back(acc + 4 + stall);
        mbeat = (mbeat + 1) % FB;
      end
    end
    @(posedge clk);
    #1;
    conv_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mbeat = 0;
  endtask

  // Write monitor: every enabled bank cycle must match the next queued write.
  always @(negedge clk) begin
    if (bram_wea === 1'b1 || bram_ena === 1'b1) begin
      checks++;
      if (wrq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got cyc %0d addr %0d data %h expected no write",
                 cyc, bram_addra, bram_dina);
      end else begin
        wr_t e;
        e = wrq.pop_front();
        if (cyc != e.cyc || bram_addra !== e.addr || bram_dina !== e.data ||
            bram_wea !== 1'b1 || bram_ena !== 1'b1) begin
          errors++;
          $display("[TB] FAIL write: got cyc %0d addr %0d data %h wea %b ena %b expected cyc %0d addr %0d data %h wea 1 ena 1",
                   cyc, bram_addra, bram_dina, bram_wea, bram_ena, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  // frame_done monitor.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      checks++;
      fdSeen++;
      if (fdq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_frame_done: got pulse at cyc %0d expected none", cyc);
      end else begin
        int c;
        c = fdq.pop_front();
        if (c != cyc) begin
          errors++;
          $display("[TB] FAIL frame_done_cycle: got %0d expected %0d", cyc, c);
        end
      end
    end
  end

  initial begin
    logic [VW-1:0] reluVec;
    rst_n = 1'b0;
    enable = 1'b1;
    conv_valid = 1'b0;
    conv1 = '0;
    conv2 = '0;
    conv3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wea", bram_wea, 0);
    checkOutput("reset_ena", bram_ena, 0);
    checkOutput("reset_addra", bram_addra, 0);
    checkOutput("reset_dina", bram_dina, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", conv_ready, 1);
    @(posedge clk);
    #1;

    // Single beat: addresses 0,1,2 then back to IDLE
    applyStimulus(splat(16'h0001), splat(16'h0002), splat(16'h0003), 3, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_hold_addra", bram_addra, 2);
    checkOutput("single_idle_wea", bram_wea, 0);

    // 17 back-to-back beats: 51 gapless writes, one frame_done, wrap to 0
    doReset();
    fdSeen = 0;
    for (int b = 0; b < 17; b++)
      applyStimulus(pattern(DW'(16'h1000 + b * 16)), pattern(DW'(16'h2000 + b * 16)),
                    pattern(DW'(16'h3000 + b * 16)), 3, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("frame_done_count", fdSeen, 1);
    checkOutput("wrap_hold_addra", bram_addra, 2);

    // Enable dropped at k=1 for 5 cycles
    doReset();
    applyStimulus(pattern(16'h0A00), pattern(16'h0B00), pattern(16'h0C00), 3, 5);
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("gap_ready", conv_ready, 0);
      checkOutput("gap_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while writing word k=1
    applyStimulus(pattern(16'h4400), pattern(16'h5500), pattern(16'h6600), 2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mbeat = 0;
    checkOutput("abort_wea", bram_wea, 0);
    checkOutput("abort_addra", bram_addra, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_dina", bram_dina, 0);
    applyStimulus(pattern(16'h0700), pattern(16'h0800), pattern(16'h0900), 3, 0);
    repeat (4) @(posedge clk);
    #1;

    // Sign-bit lanes for the optional clamp
    reluVec = splat(16'h0005);
    reluVec[0*DW +: DW] = 16'hFFF0;
    reluVec[3*DW +: DW] = 16'h8000;
    reluVec[5*DW +: DW] = 16'h7FFF;
    applyStimulus(reluVec, splat(16'hFFF0), pattern(16'h8123), 3, 0);
    repeat (6) @(posedge clk);
    #1;

    checkOutput("pending_writes", wrq.size(), 0);
    checkOutput("pending_frame_done", fdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_bank_writer.md
RESULT_BANK_WRITER -- requirements
Module: result_bank_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one signed result word.
REQ-002 SHALL have parameter LANES, default 8, number of vector lanes (one output bank per lane).
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, output bank address width.
REQ-004 SHALL have parameter FRAME_BEATS, default 16, number of accepted beats per frame (FRAME_BEATS*3 <= 2**ADDR_WIDTH).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  global run enable; low freezes all state.
REQ-008 SHALL have port conv_valid  input  1  result beat present on conv1/conv2/conv3.
REQ-009 SHALL have port conv_ready  output  1  writer can accept a beat this cycle.
REQ-010 SHALL have ports conv1, conv2, conv3  input  LANES*DATA_WIDTH each  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port bram_ena  output  1  bank port enable, shared by all lanes.
REQ-012 SHALL have port bram_wea  output  1  bank write enable, shared by all lanes.
REQ-013 SHALL have port bram_addra  output  ADDR_WIDTH  word address, shared by all lanes.
REQ-014 SHALL have port bram_dina  output  LANES*DATA_WIDTH  write data, lane i drives bank i.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after last word of a frame is written.
REQ-016 SHALL have port busy  output  1  high while state is WRITE.

Function
REQ-017 SHALL implement FSM states IDLE and WRITE with 2-bit word counter k (0..2).
REQ-018 SHALL assert conv_ready = enable && (state==IDLE || (state==WRITE && k==2)).
REQ-019 SHALL accept a beat when conv_valid && conv_ready, registering conv1..conv3 into a holding buffer at that edge.
REQ-020 SHALL, for a beat accepted at edge t, drive bram_wea=bram_ena=1 in the three cycles after t with k=0,1,2 and bram_dina = conv1, conv2, conv3 respectively.
REQ-021 SHALL drive bram_addra = beat_index*3 + k during each write cycle, beat_index counting accepted beats from 0.
REQ-022 SHALL, on acceptance during k==2, stay in WRITE with k=0 next cycle (back-to-back, one write per cycle, no bubble); otherwise return to IDLE after k==2.
REQ-023 SHALL, when the k==2 write of beat FRAME_BEATS-1 occurs, pulse frame_done in the following cycle and wrap beat_index to 0.
REQ-024 SHALL hold bram_wea=0, bram_ena=0 and bram_addra at its last value outside write cycles.
REQ-025 SHALL, with enable low, hold state, k, beat_index and buffer unchanged, force bram_wea=0, bram_ena=0, conv_ready=0 and suppress frame_done; resuming continues the interrupted write sequence at the same k.
REQ-026 SHALL ignore conv_valid when conv_ready is low; upstream holds data until acceptance.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, set state=IDLE, k=0, beat_index=0, holding buffer=0, bram_wea=0, bram_ena=0, bram_addra=0, bram_dina=0, frame_done=0, busy=0.
REQ-028 SHALL abort any in-progress beat on reset mid-WRITE; no further write of that beat occurs.

Configuration
REQ-029 SHALL support macro RESULT_WRITER_RELU_EN: when defined, each lane word is clamped to 0 if its sign bit is set before driving bram_dina; when undefined, words pass unchanged.

Structure
REQ-030 SHALL place shared constants (CONV_PER_BEAT=3, state enum type) in package systolic_pkg.
REQ-031 SHALL implement the per-lane ReLU clamp as sub-module lane_relu, instantiated LANES times via generate.

Verification
REQ-032 SHALL cover single beat: conv1 lanes=0x0001, conv2=0x0002, conv3=0x0003 -> writes at addra 0,1,2 with those data on cycles t+1..t+3, then IDLE.
REQ-033 SHALL cover back-to-back: conv_valid held high for 4 beats -> 12 consecutive write cycles, addra 0..11, no gap.
REQ-034 SHALL cover frame wrap: FRAME_BEATS=16, 17 beats -> frame_done pulse once after addra 47 write, 17th beat written at addra 0.
REQ-035 SHALL cover enable drop at k=1 for 5 cycles -> no writes during gap, k=1 write (addra 1) resumes after enable returns.
REQ-036 SHALL cover reset mid-WRITE at k=1 -> next cycle wea=0, addra=0; next beat writes at addra 0.
REQ-037 SHALL cover ReLU: RESULT_WRITER_RELU_EN defined, lane value 0xFFF0 -> written 0x0000; undefined -> written 0xFFF0.
